// File: rtl/digit_serial_mult.sv
// digit_serial_mult: sequential unsigned WIDTH x WIDTH multiplier, one digit pair per cycle.
// Optional ZERO_SKIP_EN: a zero operand completes in one cycle without entering CALC.
module digit_serial_mult #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   dataa,
    input  logic [WIDTH-1:0]   datab,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW   = 2 * WIDTH;
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [PW-1:0]      acc, acc_nxt, pp_shift;
    logic [PW-1:0]      product_r;
    logic [IW-1:0]      i_idx, j_idx;
    logic [IW:0]        dsum;
    logic [DIGIT-1:0]   a_dig, b_dig;
    logic [2*DIGIT-1:0] pp;
    logic               done_r;
    logic               zero_op;
    logic               load, skip, step, finish;
    logic               last_pair;

    // Zero-operand detection only matters when the skip path is built in
`ifdef ZERO_SKIP_EN
    always_comb begin
        zero_op = (dataa == '0) || (datab == '0);
    end
`else
    always_comb begin
        zero_op = 1'b0;
    end
`endif

    // Current digit pair, its product and its weighted contribution
    always_comb begin
        a_dig     = DIGIT'(a_reg >> (i_idx * DIGIT));
        b_dig     = DIGIT'(b_reg >> (j_idx * DIGIT));
        pp        = {{DIGIT{1'b0}}, a_dig} * {{DIGIT{1'b0}}, b_dig};
        dsum      = {1'b0, i_idx} + {1'b0, j_idx};
        pp_shift  = PW'(pp) << (dsum * DIGIT);
        acc_nxt   = acc + pp_shift;
        last_pair = (i_idx == LAST) && (j_idx == LAST);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        skip      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (zero_op) begin
                        skip = 1'b1;
                    end else begin
                        load      = 1'b1;
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                step = 1'b1;
                if (last_pair) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // Operand latch, accumulator and digit indices (j inner, i outer)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
        end else if (load) begin
            a_reg <= dataa;
            b_reg <= datab;
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
        end else if (step) begin
            acc <= acc_nxt;
            if (finish) begin
                i_idx <= '0;
                j_idx <= '0;
            end else if (j_idx == LAST) begin
                j_idx <= '0;
                i_idx <= i_idx + 1'b1;
            end else begin
                j_idx <= j_idx + 1'b1;
            end
        end
    end

    // Result register: changes only on completion or reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            product_r <= '0;
        end else if (finish) begin
            product_r <= acc_nxt;
        end else if (skip) begin
            product_r <= '0;
        end
    end

    // One-cycle completion pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_r <= 1'b0;
        end else begin
            done_r <= finish | skip;
        end
    end

    assign busy    = (state == CALC);
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_digit_serial_mult.sv
// tb_digit_serial_mult: directed checks of digit_serial_mult.
// Covers 8/4 and 16/4 configurations.
module tb_digit_serial_mult;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  dataa, datab;
    logic        busy, done;
    logic [15:0] product;

    logic        start16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [31:0] product16;

    int compared;
    int mismatched;

    digit_serial_mult #(.WIDTH(8), .DIGIT(4)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .dataa   (dataa),
        .datab   (datab),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    digit_serial_mult #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start16),
        .dataa   (a16),
        .datab   (b16),
        .busy    (busy16),
        .done    (done16),
        .product (product16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller is at a negedge; returns at the negedge after the start edge
    task automatic go(input logic [7:0] a, input logic [7:0] b);
        start = 1'b1;
        dataa = a;
        datab = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the start edge until done, and busy samples seen
    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (busy === 1'b1) nb++;
        end
    endtask

    task automatic test_reset;
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        compared++;
        if (product !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_product: got %h want 0000", product);
        end
    endtask

    task automatic test_ff;
        int n, nb;
        @(negedge clk);
        go(8'hFF, 8'hFF);
        wait_done(n, nb);
        compared++;
        if (n !== 4) begin
            mismatched++;
            $display("FAIL ff_latency: got %0d want 4", n);
        end
        compared++;
        if (nb !== 4) begin
            mismatched++;
            $display("FAIL ff_busy_cycles: got %0d want 4", nb);
        end
        compared++;
        if (product !== 16'hFE01) begin
            mismatched++;
            $display("FAIL ff_product: got %h want FE01", product);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("FAIL ff_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_back_to_back;
        int n, nb;
        @(negedge clk);
        go(8'h12, 8'h34);
        wait_done(n, nb);
        compared++;
        if (product !== 16'h03A8) begin
            mismatched++;
            $display("FAIL b2b_first: got %h want 03A8", product);
        end
        go(8'h03, 8'h05);
        compared++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0",
                     busy, done);
        end
        compared++;
        if (product !== 16'h03A8) begin
            mismatched++;
            $display("FAIL b2b_hold: got %h want 03A8", product);
        end
        wait_done(n, nb);
        compared++;
        if (n !== 4 || product !== 16'h000F) begin
            mismatched++;
            $display("FAIL b2b_second: got n=%0d p=%h want n=4 p=000F",
                     n, product);
        end
    endtask

    task automatic test_ignore_start;
        int dones;
        dones = 0;
        @(negedge clk);
        go(8'h0F, 8'h0F);
        start = 1'b1;
        dataa = 8'hAA;
        datab = 8'h55;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        compared++;
        if (dones !== 1) begin
            mismatched++;
            $display("FAIL ignore_dones: got %0d want 1", dones);
        end
        compared++;
        if (product !== 16'h00E1) begin
            mismatched++;
            $display("FAIL ignore_product: got %h want 00E1", product);
        end
    endtask

    task automatic test_reset_abort;
        int dones;
        dones = 0;
        go(8'hFF, 8'hFF);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            mismatched++;
            $display("FAIL abort_clear: got busy=%b done=%b p=%h want 0 0 0000",
                     busy, done, product);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        compared++;
        if (dones !== 0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_nodone: got dones=%0d busy=%b want 0 0",
                     dones, busy);
        end
    endtask

    task automatic test_zero;
        int n, nb;
        int exp_n;
        @(negedge clk);
        go(8'h03, 8'h05);
        wait_done(n, nb);
        @(negedge clk);
        go(8'h00, 8'h77);
        wait_done(n, nb);
`ifdef ZERO_SKIP_EN
        exp_n = 0;
`else
        exp_n = 4;
`endif
        compared++;
        if (n !== exp_n || nb !== exp_n) begin
            mismatched++;
            $display("FAIL zero_latency: got n=%0d busy=%0d want %0d",
                     n, nb, exp_n);
        end
        compared++;
        if (product !== 16'h0000) begin
            mismatched++;
            $display("FAIL zero_product: got %h want 0000", product);
        end
    endtask

    task automatic test_wide;
        int n;
        @(negedge clk);
        start16 = 1'b1;
        a16     = 16'hFFFF;
        b16     = 16'hFFFF;
        @(negedge clk);
        start16 = 1'b0;
        n = 0;
        while (done16 !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n !== 16) begin
            mismatched++;
            $display("FAIL wide_latency: got %0d want 16", n);
        end
        compared++;
        if (product16 !== 32'hFFFE0001) begin
            mismatched++;
            $display("FAIL wide_product: got %h want FFFE0001", product16);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        dataa      = '0;
        datab      = '0;
        start16    = 1'b0;
        a16        = '0;
        b16        = '0;
        repeat (2) @(negedge clk);
        test_reset;
        reset_n = 1'b1;
        test_ff;
        test_back_to_back;
        test_ignore_start;
        test_reset_abort;
        test_zero;
        test_wide;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
